// File: rtl/ramp_pkg.sv
// Shared constants and state encoding for the ramp test-pattern aligner and checker.
package ramp_pkg;

  localparam int unsigned WORD_W    = 10;
  localparam int unsigned N_WORDS   = 8;
  localparam int unsigned FRAME_W   = 80;
  localparam int unsigned N_OFFSETS = 10;
  localparam int unsigned OFF_W     = 4;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned RELOCK_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    LOCKED,
    FAIL
  } ramp_state_e;

endpackage

// File: rtl/ramp_frame_checker.sv
// Registered ramp-pattern check: every word advances by N_WORDS frame to frame,
// and words within a frame count up by one, both modulo 2^WORD_W.
module ramp_frame_checker
  import ramp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame,
  output logic               frame_ok
);

  logic [FRAME_W-1:0] frame_prev;
  logic [WORD_W-1:0]  cur_w [N_WORDS];
  logic [WORD_W-1:0]  prv_w [N_WORDS];
  logic [N_WORDS-1:0] ser_ok;
  logic [N_WORDS-2:0] par_ok;
  logic               ok_c;

  for (genvar g = 0; g < N_WORDS; g++) begin : g_serial
    assign cur_w[g]  = frame[g*WORD_W +: WORD_W];
    assign prv_w[g]  = frame_prev[g*WORD_W +: WORD_W];
    assign ser_ok[g] = (cur_w[g] == prv_w[g] + WORD_W'(N_WORDS));
  end

  for (genvar g = 0; g < N_WORDS - 1; g++) begin : g_parallel
    assign par_ok[g] = (cur_w[g+1] == cur_w[g] + WORD_W'(1));
  end

  assign ok_c = (&ser_ok) & (&par_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_prev <= '0;
      frame_ok   <= 1'b0;
    end else begin
      frame_prev <= frame;
      frame_ok   <= ok_c;
    end
  end

endmodule

// File: rtl/ramp_word_aligner.sv
// Bit-slip word aligner: searches offsets 0..9 until the ADC ramp decodes cleanly,
// then monitors it and re-searches after LOSS_THRESH consecutive bad frames.
module ramp_word_aligner
  import ramp_pkg::*;
#(
  parameter int unsigned DWELL       = 16,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned SETTLE_CYC  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [FRAME_W-1:0]  din,
  output logic [FRAME_W-1:0]  dout,
  output logic [OFF_W-1:0]    offset,
  output logic                locked,
  output logic                failed,
  output logic [RELOCK_W-1:0] relock_cnt
);

  ramp_state_e          state, state_nxt;
  logic [FRAME_W-1:0]   din_prev;
  logic [2*FRAME_W-1:0] cat;
  logic                 frame_ok;

  logic [OFF_W-1:0]     try_cnt, try_nxt, offset_nxt;
  logic [CNT_W-1:0]     settle_cnt, settle_nxt;
  logic [CNT_W-1:0]     good_cnt, good_nxt;
  logic [CNT_W-1:0]     bad_cnt, bad_nxt;
  logic [RELOCK_W-1:0]  relock_nxt;
  logic                 locked_nxt, failed_nxt;

  assign cat = {din, din_prev};

  ramp_frame_checker u_checker (
    .clk      (clk),
    .rst      (rst),
    .frame    (dout),
    .frame_ok (frame_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = SETTLE;
    end else begin
      unique case (state)
        IDLE:   state_nxt = IDLE;
        SETTLE: if (settle_cnt == CNT_W'(SETTLE_CYC)) state_nxt = CHECK;
        CHECK: begin
          if (frame_ok) begin
            if (good_cnt == CNT_W'(DWELL - 1)) state_nxt = LOCKED;
          end else if (try_cnt == OFF_W'(N_OFFSETS - 1)) begin
            state_nxt = FAIL;
          end else begin
            state_nxt = SETTLE;
          end
        end
        LOCKED: if (!frame_ok && bad_cnt == CNT_W'(LOSS_THRESH - 1)) state_nxt = SETTLE;
        FAIL:   state_nxt = FAIL;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Counter and flag updates; settle_cnt restarts from zero on every entry to SETTLE.
  always_comb begin
    offset_nxt = offset;
    try_nxt    = try_cnt;
    settle_nxt = '0;
    good_nxt   = good_cnt;
    bad_nxt    = bad_cnt;
    relock_nxt = relock_cnt;
    if (start) begin
      offset_nxt = '0;
      try_nxt    = '0;
      good_nxt   = '0;
      bad_nxt    = '0;
    end else begin
      unique case (state)
        SETTLE: begin
          settle_nxt = settle_cnt + CNT_W'(1);
          good_nxt   = '0;
        end
        CHECK: begin
          if (frame_ok) begin
            good_nxt = good_cnt + CNT_W'(1);
            bad_nxt  = '0;
          end else begin
            try_nxt = try_cnt + OFF_W'(1);
            if (try_cnt != OFF_W'(N_OFFSETS - 1))
              offset_nxt = (offset == OFF_W'(N_OFFSETS - 1)) ? '0 : offset + OFF_W'(1);
          end
        end
        LOCKED: begin
          if (frame_ok) begin
            bad_nxt = '0;
          end else if (bad_cnt == CNT_W'(LOSS_THRESH - 1)) begin
            bad_nxt    = '0;
            offset_nxt = '0;
            try_nxt    = '0;
            if (relock_cnt != '1) relock_nxt = relock_cnt + RELOCK_W'(1);
          end else begin
            bad_nxt = bad_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
    locked_nxt = (state_nxt == LOCKED);
    failed_nxt = (state_nxt == FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_prev   <= '0;
      dout       <= '0;
      offset     <= '0;
      try_cnt    <= '0;
      settle_cnt <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      relock_cnt <= '0;
      locked     <= 1'b0;
      failed     <= 1'b0;
    end else begin
      din_prev   <= din;
      dout       <= FRAME_W'(cat >> offset);
      offset     <= offset_nxt;
      try_cnt    <= try_nxt;
      settle_cnt <= settle_nxt;
      good_cnt   <= good_nxt;
      bad_cnt    <= bad_nxt;
      relock_cnt <= relock_nxt;
      locked     <= locked_nxt;
      failed     <= failed_nxt;
    end
  end

endmodule

// File: tb/tb_ramp_word_aligner.sv
// Bench for ramp_word_aligner: bit-stream ramp generator, cycle reference model, directed scenarios.
module tb_ramp_word_aligner;

  localparam int DWELL  = 16;
  localparam int LOSS   = 4;
  localparam int SETTLE = 2;

  localparam int S_IDLE = 0, S_SETTLE = 1, S_CHECK = 2, S_LOCKED = 3, S_FAIL = 4;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [79:0] din;
  logic [79:0] dout;
  logic [3:0]  offset;
  logic        locked, failed;
  logic [15:0] relock_cnt;

  always #5 clk = ~clk;

  ramp_word_aligner #(.DWELL(DWELL), .LOSS_THRESH(LOSS), .SETTLE_CYC(SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .din        (din),
    .dout       (dout),
    .offset     (offset),
    .locked     (locked),
    .failed     (failed),
    .relock_cnt (relock_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Serial stream: delay_bits of zeros, then 10-bit ramp words (base + k) mod 1024, LSB first.
  int unsigned fn, delay_bits, base;
  bit          const_mode;
  logic [79:0] xmask;

  function automatic logic [79:0] gen(input int unsigned n);
    logic [79:0] f;
    int unsigned s, p, v;
    for (int b = 0; b < 80; b++) begin
      s = 80 * n + b;
      if (const_mode) f[b] = ~b[0];
      else if (s < delay_bits) f[b] = 1'b0;
      else begin
        p = s - delay_bits;
        v = (base + p / 10) % 1024;
        f[b] = v[p % 10];
      end
    end
    return f;
  endfunction

  // Reference model state
  logic [79:0] m_prev, m_dout, m_dprev;
  bit          m_fok;
  int          m_st, m_off, m_try, m_left, m_good, m_bad, m_relock;

  function automatic bit frame_good(input logic [79:0] cur, input logic [79:0] prv);
    int c [8];
    int q [8];
    bit ok = 1;
    for (int i = 0; i < 8; i++) begin
      c[i] = int'(cur[i*10 +: 10]);
      q[i] = int'(prv[i*10 +: 10]);
      if ((q[i] + 8) % 1024 != c[i]) ok = 0;
    end
    for (int i = 0; i < 7; i++)
      if ((c[i] + 1) % 1024 != c[i+1]) ok = 0;
    return ok;
  endfunction

  task automatic enter_settle();
    m_st   = S_SETTLE;
    m_left = SETTLE + 1;
  endtask

  task automatic model_step();
    logic [79:0] nd;
    bit fok;
    int idx;
    if (rst) begin
      m_prev = '0; m_dout = '0; m_dprev = '0; m_fok = 0;
      m_st = S_IDLE; m_off = 0; m_try = 0; m_left = 0;
      m_good = 0; m_bad = 0; m_relock = 0;
      return;
    end
    for (int b = 0; b < 80; b++) begin
      idx   = m_off + b;
      nd[b] = (idx < 80) ? m_prev[idx] : din[idx-80];
    end
    fok     = m_fok;
    m_fok   = frame_good(m_dout, m_dprev);
    m_dprev = m_dout;
    m_dout  = nd;
    m_prev  = din;
    if (start) begin
      m_off = 0; m_try = 0; m_good = 0; m_bad = 0;
      enter_settle();
    end else begin
      case (m_st)
        S_SETTLE: begin
          m_left--;
          if (m_left == 0) begin m_st = S_CHECK; m_good = 0; end
        end
        S_CHECK: begin
          if (fok) begin
            m_good++;
            if (m_good == DWELL) begin m_st = S_LOCKED; m_bad = 0; end
          end else if (m_try == 9) begin
            m_st = S_FAIL;
          end else begin
            m_try++;
            m_off = (m_off + 1) % 10;
            enter_settle();
          end
        end
        S_LOCKED: begin
          if (fok) m_bad = 0;
          else begin
            m_bad++;
            if (m_bad == LOSS) begin
              if (m_relock < 65535) m_relock++;
              m_off = 0; m_try = 0; m_bad = 0;
              enter_settle();
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    din = gen(fn) ^ xmask;
    fn++;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_dout", dout, m_dout);
      chk("cyc_offset", 80'(offset), 80'(m_off));
      chk("cyc_locked", 80'(locked), 80'(m_st == S_LOCKED));
      chk("cyc_failed", 80'(failed), 80'(m_st == S_FAIL));
      chk("cyc_relock_cnt", 80'(relock_cnt), 80'(m_relock));
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic restart_ramp(input int unsigned dly, input int unsigned b0);
    rst = 1'b1; tick(); rst = 1'b0;
    const_mode = 0; delay_bits = dly; base = b0; xmask = '0; fn = 0;
    repeat (5) tick();
  endtask

  task automatic wait_locked(input int budget, input bit want, input string name);
    for (int i = 0; i < budget && locked != want; i++) tick();
    chk(name, 80'(locked), 80'(want));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] wa, wb, d;
    int seq[$];
    int last, drops;

    rst = 1'b1; start = 1'b0; din = '0; xmask = '0;
    const_mode = 0; delay_bits = 0; base = 0; fn = 0;
    tick(); tick();
    cmp_en = 1;
    chk("rst_offset", 80'(offset), 80'd0);
    chk("rst_dout", dout, 80'd0);
    chk("rst_relock", 80'(relock_cnt), 80'd0);

    // Aligned ramp, lock at offset 0 within 21 cycles of the start pulse
    restart_ramp(0, 0);
    pulse_start();
    repeat (20) tick();
    chk("t1_locked_by_21", 80'(locked), 80'd1);
    chk("t1_offset", 80'(offset), 80'd0);
    chk("t1_failed", 80'(failed), 80'd0);
    wa = dout[9:0];
    tick();
    wb = dout[9:0];
    d  = wb - wa;
    chk("t1_word0_step", 80'(d), 80'd8);
    d = dout[19:10] - dout[9:0];
    chk("t1_word_step", 80'(d), 80'd1);

    // Stream slipped by 3 bits: offsets 0,1,2,3 then lock
    restart_ramp(3, 0);
    seq.delete();
    last = int'(offset);
    seq.push_back(last);
    pulse_start();
    for (int i = 0; i < 100 && !locked; i++) begin
      tick();
      if (int'(offset) != last) begin last = int'(offset); seq.push_back(last); end
    end
    chk("t2_locked", 80'(locked), 80'd1);
    chk("t2_offset", 80'(offset), 80'd3);
    chk("t2_seq_len", 80'(seq.size()), 80'd4);
    if (seq.size() == 4) chk("t2_seq_2", 80'(seq[2]), 80'd2);
    tick();
    d = dout[79:70] - dout[9:0];
    chk("t2_aligned_span", 80'(d), 80'd7);

    // Constant 0x155 words: ten failed tries, then FAIL at offset 9
    rst = 1'b1; tick(); rst = 1'b0;
    const_mode = 1;
    pulse_start();
    repeat (50) tick();
    chk("t3_failed", 80'(failed), 80'd1);
    chk("t3_locked", 80'(locked), 80'd0);
    chk("t3_offset", 80'(offset), 80'd9);
    pulse_start();
    chk("t3_restart_failed", 80'(failed), 80'd0);
    chk("t3_restart_offset", 80'(offset), 80'd0);

    // Loss of lock: two corrupted input frames (3 bad checks) hold, three (4 bad checks) drop
    restart_ramp(0, 0);
    pulse_start();
    wait_locked(50, 1, "t4_first_lock");
    xmask = 80'h1; tick(); tick(); xmask = '0;
    repeat (8) tick();
    chk("t4_hold_locked", 80'(locked), 80'd1);
    chk("t4_hold_relock", 80'(relock_cnt), 80'd0);
    xmask = 80'h1; tick(); tick(); tick(); xmask = '0;
    wait_locked(12, 0, "t4_dropped");
    chk("t4_relock_cnt", 80'(relock_cnt), 80'd1);
    wait_locked(60, 1, "t4_relocked");
    chk("t4_relock_offset", 80'(offset), 80'd0);

    // Reset mid-CHECK at offset 5, with start held alongside reset
    const_mode = 1;
    pulse_start();
    for (int i = 0; i < 60 && !(m_st == S_CHECK && m_off == 5); i++) tick();
    chk("t6_pre_offset", 80'(offset), 80'd5);
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    chk("t6_offset", 80'(offset), 80'd0);
    chk("t6_locked", 80'(locked), 80'd0);
    chk("t6_failed", 80'(failed), 80'd0);
    chk("t6_relock", 80'(relock_cnt), 80'd0);
    chk("t6_dout", dout, 80'd0);
    repeat (10) tick();
    chk("t6_stays_idle", 80'(offset), 80'd0);

    // Ramp crosses 1023->0 mid-frame and across frames while locked
    restart_ramp(0, 708);
    pulse_start();
    wait_locked(50, 1, "t5_locked");
    drops = 0;
    repeat (45) begin
      tick();
      if (!locked) drops++;
    end
    chk("t5_lock_held", 80'(drops), 80'd0);
    chk("t5_relock", 80'(relock_cnt), 80'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ramp_word_aligner.md
Name: ramp_word_aligner

Overview:
- Sits directly upstream of the ramp error counter, between the ADC deserializer and the counter.
- Takes raw 80-bit deserialized frames whose 10-bit word boundaries may be slipped by 0..9 bits.
- Searches bit offsets with a state machine until the ADC ramp test pattern decodes cleanly, then outputs aligned 8x10-bit frames.
- Monitors the pattern after lock and re-searches on sustained loss of lock.

Parameters:
- DWELL, 16: consecutive good frames required in CHECK to declare lock (1..255).
- LOSS_THRESH, 4: consecutive bad frames in LOCKED that force a re-search (1..255).
- SETTLE_CYC, 2: frames discarded after any offset change.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins or restarts the search at offset 0
- din  in  80  raw deserializer frame; the earliest bit is din[0]
- dout  out  80  aligned frame; word i = dout[10i+9:10i]
- offset  out  4  current bit offset, 0..9
- locked  out  1  high while in LOCKED
- failed  out  1  high while in FAIL
- relock_cnt  out  16  number of lock losses since reset; saturates at 0xFFFF

Behaviour:
- Datapath:
  - din_prev <= din every cycle.
  - cat = {din, din_prev} (160 bits).
  - dout <= cat[offset+79 : offset]. Latency is 1 cycle from din to dout when offset is stable.
  - offset is a registered value, valid 0..9 only. A change takes effect on the next frame.
- Frame check (registered, 1 cycle after dout):
  - dout_prev <= dout.
  - frame_ok <= all 8 serial checks AND all 7 parallel checks:
    - serial: dout word i == dout_prev word i + 8, mod 1024;
    - parallel: dout word i+1 == dout word i + 1, mod 1024.
  - Wrap 1023->0 is legal in both checks.
- FSM states: IDLE, SETTLE, CHECK, LOCKED, FAIL.
  - Reset:
    - state = IDLE;
    - offset = 0, locked = 0, failed = 0, relock_cnt = 0;
    - dout = 0, try_cnt = 0, all internal counters = 0.
  - IDLE: on start -> SETTLE with offset = 0, try_cnt = 0.
  - SETTLE: count SETTLE_CYC+1 cycles (covers the pipeline to frame_ok), then -> CHECK with good_cnt = 0.
  - CHECK:
    - frame_ok = 1: good_cnt++. When good_cnt reaches DWELL -> LOCKED.
    - frame_ok = 0: try_cnt++.
      - If try_cnt was already 9: -> FAIL (offset holds its last value).
      - Otherwise: offset = (offset+1) mod 10, -> SETTLE.
  - LOCKED:
    - locked = 1.
    - bad_cnt counts consecutive frame_ok = 0 and is cleared by any frame_ok = 1.
    - When bad_cnt reaches LOSS_THRESH: relock_cnt++ (saturating), offset = 0, try_cnt = 0, -> SETTLE.
  - FAIL: failed = 1; hold until start.
- start in any non-IDLE state restarts the search: offset = 0, try_cnt = 0, -> SETTLE, locked/failed cleared.
- start asserted with rst: rst wins; start is ignored.
- rst mid-search or mid-lock: every output returns to its reset value on the next edge.
- dout is always driven, including while unlocked. Downstream consumers gate on locked.

Decomposition:
- Shared package ramp_pkg:
  - constants WORD_W = 10, N_WORDS = 8, FRAME_W = 80, N_OFFSETS = 10;
  - ramp state enum (IDLE, SETTLE, CHECK, LOCKED, FAIL).
- Sub-module ramp_frame_checker: registered frame_ok from dout/dout_prev. Later reusable by the error counter.
- The 160->80 offset mux stays inline.

Test Plan:
- Lock at offset 0, defaults:
  - Stimulus: aligned continuous ramp (word i of frame n = 8n+i mod 1024); start pulse at cycle 0.
  - Required: locked = 1 by cycle 21, offset = 0, failed = 0, dout word0 increments by 8 per frame.
- Lock at a slipped offset:
  - Stimulus: ramp bitstream delayed by 3 bits; start pulse.
  - Required: offset steps 0,1,2,3; locked = 1 with offset = 3; dout matches the ideal ramp.
- Failure on non-ramp data:
  - Stimulus: constant din = 0x155...; start pulse.
  - Required: after 10 offset tries, failed = 1, locked = 0, offset = 9.
  - Follow-up: a second start clears failed and restarts at offset 0.
- Loss of lock and relock:
  - Stimulus: locked on a good ramp; corrupt 3 frames -> locked stays 1; corrupt 4 consecutive frames; then restore the ramp.
  - Required: locked drops, relock_cnt = 1, re-lock occurs.
- Wrap boundary:
  - Stimulus: ramp crossing 1023->0 in both serial and parallel positions while locked.
  - Required: no drop of locked, bad_cnt stays 0.
- Reset mid-CHECK at offset 5:
  - Stimulus: assert rst for 1 cycle.
  - Required: next cycle offset = 0, locked = failed = 0, relock_cnt = 0, dout = 0, state IDLE (no search until start).
